// File: rtl/pipe_decode_pkg.sv
// Shared definitions for the LEGv8 decode stage: opcodes, control encodings
// and the packed control word carried from decode into the output register.
package pipe_decode_pkg;

  localparam logic [9:0]  OP_ADDI  = 10'b1001000100;
  localparam logic [10:0] OP_ADDS  = 11'b10101011000;
  localparam logic [10:0] OP_SUBS  = 11'b11101011000;
  localparam logic [5:0]  OP_B     = 6'b000101;
  localparam logic [5:0]  OP_BL    = 6'b100101;
  localparam logic [7:0]  OP_BCOND = 8'b01010100;
  localparam logic [7:0]  OP_CBZ   = 8'b10110100;
  localparam logic [10:0] OP_BR    = 11'b11010110000;
  localparam logic [10:0] OP_LDUR  = 11'b11111000010;
  localparam logic [10:0] OP_STUR  = 11'b11111000000;

  localparam logic [4:0] COND_LT  = 5'h0B;
  localparam logic [4:0] REG_LINK = 5'd30;
  localparam logic [4:0] REG_ZERO = 5'd31;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b011;

  typedef enum logic [1:0] {
    MTR_ALU = 2'd0,
    MTR_MEM = 2'd1,
    MTR_PC4 = 2'd2
  } memtoreg_e;

  typedef enum logic [1:0] {
    BRC_NONE   = 2'd0,
    BRC_ALWAYS = 2'd1,
    BRC_LT     = 2'd2,
    BRC_CBZ    = 2'd3
  } br_cond_e;

  // constsel marks the 12-bit immediate (ADDI) as the ALU constant rather
  // than the 9-bit load/store offset.
  typedef struct packed {
    logic      reg2loc;
    logic      alusrc;
    logic      regwrite;
    logic      memwrite;
    logic      uncondbr;
    logic      flagen;
    logic      constsel;
    memtoreg_e memtoreg;
    br_cond_e  br_cond;
    logic      br_reg;
    logic [2:0] aluop;
    logic      illegal;
  } ctrl_t;

endpackage

// File: rtl/instr_ctrl_decode.sv
// Purely combinational LEGv8 decode: instruction word to control word,
// register fields, extended immediate and source-register usage flags.
module instr_ctrl_decode
  import pipe_decode_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [31:0]       instr,
  output ctrl_t             ctrl,
  output logic [4:0]        rn,
  output logic [4:0]        rm,
  output logic [4:0]        rd,
  output logic [DATA_W-1:0] imm,
  output logic              uses_rn,
  output logic              uses_r2
);

  logic [DATA_W-1:0] imm9_s, imm12_z, imm19_s, imm26_s;

  assign imm9_s  = {{(DATA_W-9){instr[20]}}, instr[20:12]};
  assign imm12_z = {{(DATA_W-12){1'b0}}, instr[21:10]};
  assign imm19_s = {{(DATA_W-19){instr[23]}}, instr[23:5]};
  assign imm26_s = {{(DATA_W-26){instr[25]}}, instr[25:0]};

  always_comb begin
    ctrl       = '0;
    ctrl.aluop = ALU_PASS;
    rn         = instr[9:5];
    rm         = instr[20:16];
    rd         = instr[4:0];
    imm        = '0;
    uses_rn    = 1'b0;
    uses_r2    = 1'b0;
    if (instr[31:22] == OP_ADDI) begin
      ctrl.alusrc   = 1'b1;
      ctrl.regwrite = 1'b1;
      ctrl.constsel = 1'b1;
      ctrl.aluop    = ALU_ADD;
      imm           = imm12_z;
      uses_rn       = 1'b1;
    end else if (instr[31:21] == OP_ADDS || instr[31:21] == OP_SUBS) begin
      ctrl.reg2loc  = 1'b1;
      ctrl.regwrite = 1'b1;
      ctrl.flagen   = 1'b1;
      ctrl.aluop    = instr[30] ? ALU_SUB : ALU_ADD;
      uses_rn       = 1'b1;
      uses_r2       = 1'b1;
    end else if (instr[31:26] == OP_B || instr[31:26] == OP_BL) begin
      ctrl.uncondbr = 1'b1;
      ctrl.br_cond  = BRC_ALWAYS;
      imm           = imm26_s;
      // BL writes the return address (PC+4) into the link register.
      if (instr[31]) begin
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = MTR_PC4;
        rd            = REG_LINK;
      end
    end else if (instr[31:24] == OP_BCOND && instr[4:0] == COND_LT) begin
      ctrl.br_cond = BRC_LT;
      imm          = imm19_s;
    end else if (instr[31:24] == OP_CBZ) begin
      ctrl.br_cond = BRC_CBZ;
      imm          = imm19_s;
      uses_r2      = 1'b1;
    end else if (instr[31:21] == OP_BR) begin
      ctrl.uncondbr = 1'b1;
      ctrl.br_cond  = BRC_ALWAYS;
      ctrl.br_reg   = 1'b1;
      uses_rn       = 1'b1;
    end else if (instr[31:21] == OP_LDUR) begin
      ctrl.alusrc   = 1'b1;
      ctrl.regwrite = 1'b1;
      ctrl.memtoreg = MTR_MEM;
      ctrl.aluop    = ALU_ADD;
      imm           = imm9_s;
      uses_rn       = 1'b1;
    end else if (instr[31:21] == OP_STUR) begin
      ctrl.alusrc   = 1'b1;
      ctrl.memwrite = 1'b1;
      ctrl.aluop    = ALU_ADD;
      imm           = imm9_s;
      uses_rn       = 1'b1;
      uses_r2       = 1'b1;
    end else begin
      ctrl.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/pipe_decode.sv
// Decode pipeline stage: one-cycle decode register with valid/ready
// handshakes, load-use bubble insertion, flush and performance counters.
module pipe_decode
  import pipe_decode_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int PC_W   = 64,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_valid,
  input  logic [31:0]       if_instr,
  input  logic [PC_W-1:0]   if_pc,
  output logic              if_ready,
  input  logic              flush,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [4:0]        id_rn,
  output logic [4:0]        id_rm,
  output logic [4:0]        id_rd,
  output logic [DATA_W-1:0] id_imm,
  output logic [PC_W-1:0]   id_pc,
  output logic              id_reg2loc,
  output logic              id_alusrc,
  output logic              id_regwrite,
  output logic              id_memwrite,
  output logic              id_uncondbr,
  output logic              id_flagen,
  output logic              id_constsel,
  output logic [1:0]        id_memtoreg,
  output logic [1:0]        id_br_cond,
  output logic              id_br_reg,
  output logic [2:0]        id_aluop,
  output logic              id_illegal,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  illegal_cnt
);

  ctrl_t             ctrl_d, ctrl_q, ctrl_o;
  logic [4:0]        rn_d, rm_d, rd_d;
  logic [DATA_W-1:0] imm_d;
  logic              uses_rn_d, uses_r2_d;
  logic              load_pending, hazard, slot_free;

  instr_ctrl_decode #(.DATA_W(DATA_W)) u_decode (
    .instr   (if_instr),
    .ctrl    (ctrl_d),
    .rn      (rn_d),
    .rm      (rm_d),
    .rd      (rd_d),
    .imm     (imm_d),
    .uses_rn (uses_rn_d),
    .uses_r2 (uses_r2_d)
  );

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // id_* stays stable while id_valid && !id_ready; if_ready never depends
  // on if_valid except through the load-use hazard check.
  assign load_pending = id_valid && (ctrl_q.memtoreg == MTR_MEM) && (id_rd != REG_ZERO);
  assign hazard = if_valid && load_pending &&
                  ((uses_rn_d && rn_d == id_rd) ||
                   (uses_r2_d && (ctrl_d.reg2loc ? rm_d : rd_d) == id_rd));
  assign slot_free = !id_valid || id_ready;
  assign if_ready  = flush || (slot_free && !hazard);

  always_ff @(posedge clk) begin
    if (reset) begin
      id_valid    <= 1'b0;
      ctrl_q      <= '0;
      id_rn       <= '0;
      id_rm       <= '0;
      id_rd       <= '0;
      id_imm      <= '0;
      id_pc       <= '0;
      bubble_cnt  <= '0;
      illegal_cnt <= '0;
    end else if (flush) begin
      id_valid <= 1'b0;
    end else if (slot_free) begin
      if (if_valid && !hazard) begin
        id_valid <= 1'b1;
        ctrl_q   <= ctrl_d;
        id_rn    <= rn_d;
        id_rm    <= rm_d;
        id_rd    <= rd_d;
        id_imm   <= imm_d;
        id_pc    <= if_pc;
        if (ctrl_d.illegal && illegal_cnt != '1)
          illegal_cnt <= illegal_cnt + CNT_W'(1);
      end else begin
        id_valid <= 1'b0;
        if (hazard && bubble_cnt != '1)
          bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
    end
  end

  // An empty slot must look like a NOP downstream.
  assign ctrl_o = id_valid ? ctrl_q : '0;

  assign id_reg2loc  = ctrl_o.reg2loc;
  assign id_alusrc   = ctrl_o.alusrc;
  assign id_regwrite = ctrl_o.regwrite;
  assign id_memwrite = ctrl_o.memwrite;
  assign id_uncondbr = ctrl_o.uncondbr;
  assign id_flagen   = ctrl_o.flagen;
  assign id_constsel = ctrl_o.constsel;
  assign id_memtoreg = ctrl_o.memtoreg;
  assign id_br_cond  = ctrl_o.br_cond;
  assign id_br_reg   = ctrl_o.br_reg;
  assign id_aluop    = ctrl_o.aluop;
  assign id_illegal  = ctrl_o.illegal;

endmodule

// File: tb/tb_pipe_decode.sv
// Bench for pipe_decode: directed scenarios followed by randomized traffic
// checked cycle by cycle against a table-driven reference model.
module tb_pipe_decode;

  localparam int DATA_W = 64;
  localparam int PC_W   = 64;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              reset, if_valid, flush, id_ready;
  logic [31:0]       if_instr;
  logic [PC_W-1:0]   if_pc;
  logic              if_ready, id_valid;
  logic [4:0]        id_rn, id_rm, id_rd;
  logic [DATA_W-1:0] id_imm;
  logic [PC_W-1:0]   id_pc;
  logic id_reg2loc, id_alusrc, id_regwrite, id_memwrite, id_uncondbr, id_flagen, id_constsel;
  logic [1:0]        id_memtoreg, id_br_cond;
  logic              id_br_reg, id_illegal;
  logic [2:0]        id_aluop;
  logic [CNT_W-1:0]  bubble_cnt, illegal_cnt;

  // clock / reset
  always #5 clk = ~clk;

  pipe_decode #(.DATA_W(DATA_W), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .if_ready(if_ready), .flush(flush), .id_valid(id_valid), .id_ready(id_ready),
    .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd), .id_imm(id_imm), .id_pc(id_pc),
    .id_reg2loc(id_reg2loc), .id_alusrc(id_alusrc), .id_regwrite(id_regwrite),
    .id_memwrite(id_memwrite), .id_uncondbr(id_uncondbr), .id_flagen(id_flagen),
    .id_constsel(id_constsel), .id_memtoreg(id_memtoreg), .id_br_cond(id_br_cond),
    .id_br_reg(id_br_reg), .id_aluop(id_aluop), .id_illegal(id_illegal),
    .bubble_cnt(bubble_cnt), .illegal_cnt(illegal_cnt)
  );

  typedef struct packed {
    logic reg2loc, alusrc, regwrite, memwrite, uncondbr, flagen, constsel;
    logic [1:0] memtoreg;
    logic [1:0] br_cond;
    logic       br_reg;
    logic [2:0] aluop;
    logic       illegal;
  } ctl_t;

  typedef struct packed {
    ctl_t        c;
    logic [4:0]  rn, rm, rd, r2;
    logic [63:0] imm;
    logic        reads_rn, reads_r2, is_load;
  } ref_t;

  typedef enum int {K_ADDI, K_ADDS, K_SUBS, K_B, K_BL, K_BLT, K_CBZ, K_BR, K_LDUR, K_STUR, K_ILL} kind_e;

  localparam logic [31:0] PAT_MASK [10] = '{32'hFFC0_0000, 32'hFFE0_0000, 32'hFFE0_0000,
    32'hFC00_0000, 32'hFC00_0000, 32'hFF00_001F, 32'hFF00_0000, 32'hFFE0_0000,
    32'hFFE0_0000, 32'hFFE0_0000};
  localparam logic [31:0] PAT_VAL [10] = '{32'h9100_0000, 32'hAB00_0000, 32'hEB00_0000,
    32'h1400_0000, 32'h9400_0000, 32'h5400_000B, 32'hB400_0000, 32'hD600_0000,
    32'hF840_0000, 32'hF800_0000};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic kind_e kind_of(input logic [31:0] w);
    for (int k = 0; k < 10; k++)
      if ((w & PAT_MASK[k]) == PAT_VAL[k]) return kind_e'(k);
    return K_ILL;
  endfunction

  function automatic ref_t ref_decode(input logic [31:0] w);
    ref_t r;
    r = '0;
    r.rn = w[9:5];
    r.rm = w[20:16];
    r.rd = w[4:0];
    case (kind_of(w))
      K_ADDI: begin
        r.c.alusrc = 1; r.c.regwrite = 1; r.c.constsel = 1; r.c.aluop = 3'b010;
        r.imm = 64'(w[21:10]); r.reads_rn = 1;
      end
      K_ADDS, K_SUBS: begin
        r.c.reg2loc = 1; r.c.regwrite = 1; r.c.flagen = 1;
        r.c.aluop = (kind_of(w) == K_SUBS) ? 3'b011 : 3'b010;
        r.reads_rn = 1; r.reads_r2 = 1; r.r2 = w[20:16];
      end
      K_B, K_BL: begin
        r.c.uncondbr = 1; r.c.br_cond = 2'd1;
        r.imm = 64'(longint'($signed(w[25:0])));
        if (kind_of(w) == K_BL) begin
          r.c.regwrite = 1; r.c.memtoreg = 2'd2; r.rd = 5'd30;
        end
      end
      K_BLT: begin
        r.c.br_cond = 2'd2; r.imm = 64'(longint'($signed(w[23:5])));
      end
      K_CBZ: begin
        r.c.br_cond = 2'd3; r.imm = 64'(longint'($signed(w[23:5])));
        r.reads_r2 = 1; r.r2 = w[4:0];
      end
      K_BR: begin
        r.c.uncondbr = 1; r.c.br_cond = 2'd1; r.c.br_reg = 1; r.reads_rn = 1;
      end
      K_LDUR: begin
        r.c.alusrc = 1; r.c.regwrite = 1; r.c.memtoreg = 2'd1; r.c.aluop = 3'b010;
        r.imm = 64'(longint'($signed(w[20:12]))); r.reads_rn = 1; r.is_load = 1;
      end
      K_STUR: begin
        r.c.alusrc = 1; r.c.memwrite = 1; r.c.aluop = 3'b010;
        r.imm = 64'(longint'($signed(w[20:12]))); r.reads_rn = 1; r.reads_r2 = 1; r.r2 = w[4:0];
      end
      default: r.c.illegal = 1;
    endcase
    return r;
  endfunction

  // reference model state: what the decode register should hold
  logic             m_valid = 1'b0;
  ref_t             m_r = '0;
  logic [PC_W-1:0]  m_pc = '0;
  logic [CNT_W-1:0] m_bub = '0, m_ill = '0;
  logic [PC_W-1:0]  exp_q[$];
  logic [PC_W-1:0]  obs_pc = '0;

  function automatic logic ref_hazard(input ref_t nd);
    return if_valid && m_valid && m_r.is_load && (m_r.rd != 5'd31) &&
           ((nd.reads_rn && nd.rn == m_r.rd) || (nd.reads_r2 && nd.r2 == m_r.rd));
  endfunction

  function automatic logic ref_if_ready();
    return flush || ((!m_valid || id_ready) && !ref_hazard(ref_decode(if_instr)));
  endfunction

  task automatic model_edge();
    ref_t nd;
    logic hz;
    logic [PC_W-1:0] sb_pc;
    nd = ref_decode(if_instr);
    hz = ref_hazard(nd);
    if (reset) begin
      m_valid = 0; m_r = '0; m_pc = '0; m_bub = '0; m_ill = '0;
      exp_q.delete();
    end else begin
      if (m_valid && (flush || id_ready) && exp_q.size() > 0) begin
        sb_pc = exp_q.pop_front();
        if (!flush) check("sb_retire_pc", 64'(obs_pc), 64'(sb_pc));
      end
      if (flush) m_valid = 0;
      else if (!m_valid || id_ready) begin
        if (if_valid && !hz) begin
          m_valid = 1; m_r = nd; m_pc = if_pc;
          exp_q.push_back(if_pc);
          if (nd.c.illegal && m_ill != '1) m_ill++;
        end else begin
          m_valid = 0;
          if (hz && m_bub != '1) m_bub++;
        end
      end
    end
  endtask

  task automatic compare_outputs();
    ctl_t got;
    got = {id_reg2loc, id_alusrc, id_regwrite, id_memwrite, id_uncondbr, id_flagen,
           id_constsel, id_memtoreg, id_br_cond, id_br_reg, id_aluop, id_illegal};
    check("id_valid", 64'(id_valid), 64'(m_valid));
    check("ctrl", 64'(got), 64'(m_valid ? m_r.c : ctl_t'(0)));
    if (m_valid) begin
      check("id_rn", 64'(id_rn), 64'(m_r.rn));
      check("id_rm", 64'(id_rm), 64'(m_r.rm));
      check("id_rd", 64'(id_rd), 64'(m_r.rd));
      check("id_imm", 64'(id_imm), m_r.imm);
      check("id_pc", 64'(id_pc), 64'(m_pc));
    end
    check("bubble_cnt", 64'(bubble_cnt), 64'(m_bub));
    check("illegal_cnt", 64'(illegal_cnt), 64'(m_ill));
    obs_pc = id_pc;
  endtask

  // driver tasks
  task automatic drive(input logic rst, input logic v, input logic [31:0] ins,
                       input logic [PC_W-1:0] pc, input logic rdy, input logic fl);
    reset = rst; if_valid = v; if_instr = ins; if_pc = pc; id_ready = rdy; flush = fl;
    #1;
    if (!rst) check("if_ready", 64'(if_ready), 64'(ref_if_ready()));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_outputs();
  endtask

  function automatic logic [4:0] rreg();
    int k;
    k = $urandom_range(0, 4);
    return (k == 4) ? 5'd31 : 5'(k);
  endfunction

  function automatic logic [31:0] rand_instr();
    case ($urandom_range(0, 11))
      0:  return {10'h244, 12'($urandom), rreg(), rreg()};
      1:  return {11'h558, rreg(), 6'($urandom), rreg(), rreg()};
      2:  return {11'h758, rreg(), 6'($urandom), rreg(), rreg()};
      3:  return {6'b000101, 26'($urandom)};
      4:  return {6'b100101, 26'($urandom)};
      5:  return {8'h54, 19'($urandom), 5'h0B};
      6:  return {8'h54, 19'($urandom), 5'($urandom)};
      7:  return {8'hB4, 19'($urandom), rreg()};
      8:  return {11'h6B0, 5'h1F, 6'h00, rreg(), 5'h00};
      9:  return {11'h7C2, 9'($urandom), 2'b00, rreg(), rreg()};
      10: return {11'h7C0, 9'($urandom), 2'b00, rreg(), rreg()};
      default: return $urandom;
    endcase
  endfunction

  initial begin
    drive(1, 0, 32'h0, '0, 1, 0);
    tick(); tick();
    check("rst_valid", 64'(id_valid), 64'd0);
    check("rst_imm", 64'(id_imm), 64'd0);
    check("rst_rd", 64'(id_rd), 64'd0);
    check("rst_bubble", 64'(bubble_cnt), 64'd0);

    // ADDI X1, X2, #5
    drive(0, 1, 32'h91001441, 64'h1000, 1, 0);
    check("rdy_after_rst", 64'(if_ready), 64'd1);
    tick();
    check("addi_rd", 64'(id_rd), 64'd1);
    check("addi_rn", 64'(id_rn), 64'd2);
    check("addi_imm", 64'(id_imm), 64'd5);
    check("addi_alusrc", 64'(id_alusrc), 64'd1);
    check("addi_regwrite", 64'(id_regwrite), 64'd1);
    check("addi_aluop", 64'(id_aluop), 64'd2);

    // LDUR X3,[X2] then dependent ADDS X4,X3,X1
    drive(0, 1, 32'hF8400043, 64'h1004, 1, 0);
    tick();
    drive(0, 1, 32'hAB010064, 64'h1008, 1, 0);
    check("lu_stall_rdy", 64'(if_ready), 64'd0);
    tick();
    check("lu_bubble_valid", 64'(id_valid), 64'd0);
    check("lu_bubble_cnt", 64'(bubble_cnt), 64'd1);
    drive(0, 1, 32'hAB010064, 64'h1008, 1, 0);
    tick();
    check("adds_valid", 64'(id_valid), 64'd1);
    check("adds_flagen", 64'(id_flagen), 64'd1);
    check("adds_rd", 64'(id_rd), 64'd4);

    // B.LT -2
    drive(0, 1, 32'h54FFFFCB, 64'h100C, 1, 0);
    tick();
    check("blt_cond", 64'(id_br_cond), 64'd2);
    check("blt_imm", 64'(id_imm), 64'hFFFF_FFFF_FFFF_FFFE);

    // hold ADDI for three cycles, then flush
    drive(0, 1, 32'h91001441, 64'h1010, 1, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 32'hAB010064, 64'h1014, 0, 0);
      check("hold_rdy", 64'(if_ready), 64'd0);
      tick();
      check("hold_rd", 64'(id_rd), 64'd1);
      check("hold_imm", 64'(id_imm), 64'd5);
      check("hold_pc", 64'(id_pc), 64'h1010);
    end
    drive(0, 1, 32'hAB010064, 64'h1014, 0, 1);
    check("flush_rdy", 64'(if_ready), 64'd1);
    tick();
    check("flush_valid", 64'(id_valid), 64'd0);

    // illegal all-zero word, then reset while it is stalled
    drive(0, 1, 32'h0, 64'h2000, 1, 0);
    tick();
    check("ill_flag", 64'(id_illegal), 64'd1);
    check("ill_regwrite", 64'(id_regwrite), 64'd0);
    check("ill_memwrite", 64'(id_memwrite), 64'd0);
    check("ill_cnt", 64'(illegal_cnt), 64'd1);
    drive(0, 0, 32'h0, 64'h2004, 0, 0);
    tick();
    drive(1, 1, 32'hF8400043, 64'h2008, 0, 0);
    tick();
    check("rst2_valid", 64'(id_valid), 64'd0);
    check("rst2_illegal", 64'(id_illegal), 64'd0);
    check("rst2_pc", 64'(id_pc), 64'd0);
    check("rst2_ill_cnt", 64'(illegal_cnt), 64'd0);
    check("rst2_bub_cnt", 64'(bubble_cnt), 64'd0);

    for (int i = 0; i < 4000; i++) begin
      drive(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0), rand_instr(),
            {$urandom, $urandom}, ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
      tick();
    end
    drive(0, 0, 32'h0, '0, 1, 0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
